// File: rtl/ex_mem_pkg.sv
// Shared types and widths for the EX/MEM pipeline stage.
package ex_mem_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    // One instruction's worth of state carried from EX into MEM.
    typedef struct packed {
        logic [DATA_W-1:0]     alu_result;
        logic                  zero;
        logic [DATA_W-1:0]     store_data;
        logic [REG_ADDR_W-1:0] wb_reg;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic [DATA_W-1:0]     branch_target;
    } ex_mem_entry_t;

    localparam int ENTRY_W = $bits(ex_mem_entry_t);

    // Occupancy of the two-slot skid buffer.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_MAIN  = 2'd1,
        OCC_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/ex_mem_skid.sv
// Generic two-slot skid buffer with flush. MAIN drives the output; SKID
// catches the one extra entry EX may send after MEM stalls, so in_ready
// only ever depends on flopped state.
//
// state     | meaning
// ----------+------------------------------------------
// OCC_EMPTY | no entry held, out_valid=0, in_ready=1
// OCC_MAIN  | MAIN holds an entry, SKID empty
// OCC_FULL  | MAIN and SKID both hold entries, in_ready=0
module ex_mem_skid
    import ex_mem_pkg::*;
#(
    parameter int W = ENTRY_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_t state_q, state_d;
    logic [W-1:0] main_q, skid_q;
    logic         accept, drain;
    logic         load_main_in, load_main_skid, load_skid;

    assign in_ready  = (state_q != OCC_FULL);
    assign out_valid = (state_q != OCC_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready;
    assign drain     = out_valid & out_ready;

    // Occupancy state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= OCC_EMPTY;
        else          state_q <= state_d;
    end

    // Next occupancy and slot load strobes; flush wins over everything.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            OCC_EMPTY: begin
                if (accept) begin
                    state_d      = OCC_MAIN;
                    load_main_in = 1'b1;
                end
            end
            OCC_MAIN: begin
                if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    state_d   = OCC_FULL;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (drain) begin
                    state_d        = OCC_MAIN;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = OCC_EMPTY;
        endcase
        if (flush) state_d = OCC_EMPTY;
    end

    // Slot payloads; only the valid bits are squashed by flush.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_data;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_data;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register built on a two-slot skid buffer.
// Optional macro EX_MEM_BRANCH_RESOLVE_EN: resolve BEQ-style branches here,
// pulsing branch_taken / redirect_pc and discarding the one wrong-path entry
// accepted during the pulse.
module ex_mem_stage
    import ex_mem_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic                  alu_zero,
    input  logic [DATA_W-1:0]     store_data,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic                  reg_write,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic                  branch,
    input  logic [DATA_W-1:0]     branch_target,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_alu_result,
    output logic [DATA_W-1:0]     out_store_data,
    output logic [REG_ADDR_W-1:0] out_wb_reg,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_branch,
    output logic                  out_zero
`ifdef EX_MEM_BRANCH_RESOLVE_EN
    ,
    output logic                  branch_taken,
    output logic [DATA_W-1:0]     redirect_pc
`endif
);

    ex_mem_entry_t in_entry, out_entry;
    logic          skid_in_valid;
    logic          unused_fields;

    // Pack the EX-side fields into one entry.
    always_comb begin
        in_entry               = '0;
        in_entry.alu_result    = alu_result;
        in_entry.zero          = alu_zero;
        in_entry.store_data    = store_data;
        in_entry.wb_reg        = wb_reg;
        in_entry.reg_write     = reg_write;
        in_entry.mem_read      = mem_read;
        in_entry.mem_write     = mem_write;
        in_entry.branch        = branch;
        in_entry.branch_target = branch_target;
    end

`ifdef EX_MEM_BRANCH_RESOLVE_EN
    logic              taken_q;
    logic [DATA_W-1:0] redirect_q;
    logic              accept, take_d;

    assign accept = in_valid & in_ready;
    // A squashed branch must not redirect fetch; a wrong-path branch is ignored.
    assign take_d = accept & ~taken_q & branch & alu_zero & ~flush;

    // One-cycle taken pulse and a redirect target held until the next taken branch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            taken_q    <= 1'b0;
            redirect_q <= '0;
        end else begin
            taken_q <= take_d;
            if (take_d) redirect_q <= branch_target;
        end
    end

    // EX still sees its handshake complete during the pulse; the entry is just dropped.
    assign skid_in_valid = in_valid & ~taken_q;
    assign branch_taken  = taken_q;
    assign redirect_pc   = redirect_q;
`else
    assign skid_in_valid = in_valid;
`endif

    ex_mem_skid #(.W(ENTRY_W)) u_skid (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (skid_in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_entry)
    );

    assign out_alu_result = out_entry.alu_result;
    assign out_store_data = out_entry.store_data;
    assign out_wb_reg     = out_entry.wb_reg;
    assign out_reg_write  = out_entry.reg_write;
    assign out_mem_read   = out_entry.mem_read;
    assign out_mem_write  = out_entry.mem_write;
    assign out_branch     = out_entry.branch;
    assign out_zero       = out_entry.zero;

    // The target travels with the entry but fetch redirect uses the EX-side copy.
    assign unused_fields = ^out_entry.branch_target;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: step tables plus hand sequences, scoreboarded.
module tb_ex_mem_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] alu_result = '0;
    logic        alu_zero = 1'b0;
    logic [15:0] store_data = '0;
    logic [2:0]  wb_reg = '0;
    logic        reg_write = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        branch = 1'b0;
    logic [15:0] branch_target = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_alu_result;
    logic [15:0] out_store_data;
    logic [2:0]  out_wb_reg;
    logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_zero;
`ifdef EX_MEM_BRANCH_RESOLVE_EN
    logic        branch_taken;
    logic [15:0] redirect_pc;
`endif

    ex_mem_stage dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result     (alu_result),
        .alu_zero       (alu_zero),
        .store_data     (store_data),
        .wb_reg         (wb_reg),
        .reg_write      (reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .branch         (branch),
        .branch_target  (branch_target),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_result (out_alu_result),
        .out_store_data (out_store_data),
        .out_wb_reg     (out_wb_reg),
        .out_reg_write  (out_reg_write),
        .out_mem_read   (out_mem_read),
        .out_mem_write  (out_mem_write),
        .out_branch     (out_branch),
        .out_zero       (out_zero)
`ifdef EX_MEM_BRANCH_RESOLVE_EN
        ,
        .branch_taken   (branch_taken),
        .redirect_pc    (redirect_pc)
`endif
    );

    always #5 clock = ~clock;

    // ov: 0 = expect out_valid 0, 1 = expect out_valid 1 holding eo, 2 = not checked
    typedef struct {
        bit          iv;
        logic [15:0] alu;
        bit          zero;
        bit          br;
        logic [15:0] bt;
        bit          ord;
        bit          fl;
        bit          ir;
        int          ov;
        logic [15:0] eo;
    } step_t;

    step_t       steps[$];
    logic [39:0] sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    bit          m_taken = 1'b0;
    logic [15:0] m_redirect = '0;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h required=%0h", name, got, exp);
    endtask

    function automatic logic [39:0] got_vec();
        return {out_alu_result, out_zero, out_store_data, out_wb_reg,
                out_reg_write, out_mem_read, out_mem_write, out_branch};
    endfunction

    function automatic logic [39:0] cur_vec();
        return {alu_result, alu_zero, store_data, wb_reg,
                reg_write, mem_read, mem_write, branch};
    endfunction

    function automatic step_t mk(bit iv, logic [15:0] alu, bit ord, bit ir, int ov, logic [15:0] eo);
        step_t s;
        s.iv = iv; s.alu = alu; s.zero = 1'b0; s.br = 1'b0; s.bt = '0;
        s.ord = ord; s.fl = 1'b0; s.ir = ir; s.ov = ov; s.eo = eo;
        return s;
    endfunction

    task automatic apply(step_t s);
        in_valid      = s.iv;
        alu_result    = s.alu;
        alu_zero      = s.zero;
        store_data    = ~s.alu;
        wb_reg        = s.alu[2:0];
        reg_write     = s.alu[0];
        mem_read      = s.alu[1];
        mem_write     = s.alu[2];
        branch        = s.br;
        branch_target = s.bt;
        out_ready     = s.ord;
        flush         = s.fl;
    endtask

    // One clock: score the drain and accept the next edge will perform.
    task automatic cycle();
        logic        acc, drn, tk_next;
        logic [15:0] rd_next;
        logic [39:0] e;
        @(negedge clock);
        acc = in_valid & in_ready;
        drn = out_valid & out_ready;
        tk_next = 1'b0;
        rd_next = m_redirect;
        if (drn) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output got=%0h required=none", got_vec());
            end else begin
                e = sb.pop_front();
                check("out_entry", 64'(got_vec()), 64'(e));
            end
        end
        if (flush) sb.delete();
        else if (acc) begin
`ifdef EX_MEM_BRANCH_RESOLVE_EN
            if (!m_taken) sb.push_back(cur_vec());
            tk_next = ~m_taken & branch & alu_zero;
            if (tk_next) rd_next = branch_target;
`else
            sb.push_back(cur_vec());
`endif
        end
        @(posedge clock);
        #1;
        m_taken = tk_next;
        m_redirect = rd_next;
`ifdef EX_MEM_BRANCH_RESOLVE_EN
        check("branch_taken", 64'(branch_taken), 64'(m_taken));
        check("redirect_pc", 64'(redirect_pc), 64'(m_redirect));
`endif
    endtask

    task automatic run_table(string name);
        foreach (steps[i]) begin
            apply(steps[i]);
            check($sformatf("%s_in_ready[%0d]", name, i), 64'(in_ready), 64'(steps[i].ir));
            if (steps[i].ov != 2)
                check($sformatf("%s_out_valid[%0d]", name, i), 64'(out_valid), 64'(steps[i].ov));
            if (steps[i].ov == 1)
                check($sformatf("%s_held[%0d]", name, i), 64'(out_alu_result), 64'(steps[i].eo));
            cycle();
        end
        steps.delete();
    endtask

    task automatic drain(string name);
        bit done = 1'b0;
        in_valid = 1'b0; flush = 1'b0; branch = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && !out_valid) begin
                done = 1'b1;
                break;
            end
            cycle();
        end
        check({name, "_drain_done"}, 64'(done), 64'd1);
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step_t s;

        // Reset state, during and after reset
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_fields", 64'(got_vec()), 64'd0);
`ifdef EX_MEM_BRANCH_RESOLVE_EN
        check("rst_branch_taken", 64'(branch_taken), 64'd0);
        check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
`endif
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Single accept
        in_valid = 1'b1; alu_result = 16'h1234; wb_reg = 3'd3; reg_write = 1'b1;
        store_data = 16'h0000; mem_read = 1'b0; mem_write = 1'b0; out_ready = 1'b1;
        cycle();
        check("single_out_valid", 64'(out_valid), 64'd1);
        check("single_alu", 64'(out_alu_result), 64'h1234);
        check("single_wb_reg", 64'(out_wb_reg), 64'd3);
        in_valid = 1'b0;
        cycle();
        check("single_gone", 64'(out_valid), 64'd0);

        // Back-to-back stream at full throughput
        for (int i = 0; i < 8; i++)
            steps.push_back(mk(1'b1, 16'(i + 1), 1'b1, 1'b1, (i == 0) ? 0 : 1, 16'(i)));
        run_table("stream");
        drain("stream");

        // MEM stalls four cycles mid-stream
        steps.push_back(mk(1'b1, 16'hA000, 1'b0, 1'b1, 0, 16'h0));
        steps.push_back(mk(1'b1, 16'hA001, 1'b0, 1'b1, 1, 16'hA000));
        steps.push_back(mk(1'b1, 16'hA002, 1'b0, 1'b0, 1, 16'hA000));
        steps.push_back(mk(1'b1, 16'hA002, 1'b0, 1'b0, 1, 16'hA000));
        steps.push_back(mk(1'b1, 16'hA002, 1'b1, 1'b0, 1, 16'hA000));
        steps.push_back(mk(1'b1, 16'hA002, 1'b1, 1'b1, 1, 16'hA001));
        run_table("stall");
        drain("stall");

        // Flush with both slots full, then flush overriding a live accept
        steps.push_back(mk(1'b1, 16'hC001, 1'b0, 1'b1, 0, 16'h0));
        steps.push_back(mk(1'b1, 16'hC002, 1'b0, 1'b1, 1, 16'hC001));
        s = mk(1'b1, 16'hBEEF, 1'b0, 1'b0, 1, 16'hC001); s.fl = 1'b1; steps.push_back(s);
        steps.push_back(mk(1'b0, 16'h0, 1'b1, 1'b1, 0, 16'h0));
        steps.push_back(mk(1'b1, 16'hC003, 1'b0, 1'b1, 0, 16'h0));
        s = mk(1'b1, 16'hD00D, 1'b0, 1'b1, 1, 16'hC003); s.fl = 1'b1; steps.push_back(s);
        steps.push_back(mk(1'b0, 16'h0, 1'b1, 1'b1, 0, 16'h0));
        steps.push_back(mk(1'b0, 16'h0, 1'b1, 1'b1, 0, 16'h0));
        run_table("flush");
        drain("flush");

`ifdef EX_MEM_BRANCH_RESOLVE_EN
        // Taken branch discards the next entry; not-taken branch does not
        s = mk(1'b1, 16'h0B00, 1'b1, 1'b1, 0, 16'h0); s.br = 1'b1; s.zero = 1'b1; s.bt = 16'h0040;
        steps.push_back(s);
        steps.push_back(mk(1'b1, 16'h5555, 1'b1, 1'b1, 1, 16'h0B00));
        steps.push_back(mk(1'b0, 16'h0, 1'b1, 1'b1, 0, 16'h0));
        s = mk(1'b1, 16'h0B01, 1'b1, 1'b1, 0, 16'h0); s.br = 1'b1; s.bt = 16'h0080;
        steps.push_back(s);
        steps.push_back(mk(1'b1, 16'h5555, 1'b1, 1'b1, 1, 16'h0B01));
        steps.push_back(mk(1'b0, 16'h0, 1'b1, 1'b1, 1, 16'h5555));
        run_table("branch");
        drain("branch");
`endif

        // Async reset with SKID full and MEM stalled
        steps.push_back(mk(1'b1, 16'hE001, 1'b0, 1'b1, 0, 16'h0));
        steps.push_back(mk(1'b1, 16'hE002, 1'b0, 1'b1, 1, 16'hE001));
        run_table("prefill");
        in_valid = 1'b0;
        check("full_in_ready", 64'(in_ready), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_in_ready", 64'(in_ready), 64'd1);
        check("async_fields", 64'(out_alu_result), 64'd0);
        sb.delete();
        m_taken = 1'b0;
        m_redirect = '0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        steps.push_back(mk(1'b1, 16'hF00D, 1'b1, 1'b1, 0, 16'h0));
        steps.push_back(mk(1'b0, 16'h0, 1'b1, 1'b1, 1, 16'hF00D));
        run_table("after_rst");
        drain("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
